// File: rtl/approx_sad_pkg.sv
// Shared types and helpers for the approximate sum-of-absolute-differences accumulator.
package approx_sad_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  function automatic int sum_width(int data_w, int lanes, int block_len);
    return data_w + $clog2(lanes) + $clog2(block_len);
  endfunction

endpackage

// File: rtl/approx_absdiff_lane.sv
// One lane of |a-b|, with the low DROP_LSB bits forced to zero in approximate mode.
module approx_absdiff_lane #(
  parameter int DATA_W   = 2,
  parameter int DROP_LSB = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              approx,
  output logic [DATA_W-1:0] d
);

  localparam logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b1}} << DROP_LSB;

  logic [DATA_W-1:0] diff;

  assign diff = (a > b) ? (a - b) : (b - a);
  assign d    = approx ? (diff & KEEP_MASK) : diff;

endmodule

// File: rtl/approx_sad_accum.sv
// Pipelined block SAD accumulator: stage 1 registers the per-beat lane sum, stage 2 accumulates.
// Optional error monitor (parallel exact path, out_err/out_err_exceed) under APPROX_SAD_ERR_MON_EN.
module approx_sad_accum
  import approx_sad_pkg::*;
#(
  parameter int DATA_W    = 2,
  parameter int LANES     = 4,
  parameter int BLOCK_LEN = 8,
  parameter int DROP_LSB  = 1,
`ifdef APPROX_SAD_ERR_MON_EN
  parameter int ET_BLOCK  = 16,
`endif
  localparam int SUM_W = sum_width(DATA_W, LANES, BLOCK_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        out_sum,
`ifdef APPROX_SAD_ERR_MON_EN
  output logic [SUM_W-1:0]        out_err,
  output logic                    out_err_exceed,
`endif
  output logic                    out_mode
);

  localparam int LANE_W = DATA_W + $clog2(LANES);
  localparam int CNT_W  = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_LEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic               mode_q;
  logic               s1_valid;
  logic               s1_last;
  logic [LANE_W-1:0]  s1_sum;
  logic [SUM_W-1:0]   acc;

  logic               beat_fire;
  logic               beat_last;
  logic               beat_mode;
  logic [DATA_W-1:0]  lane_d [LANES];
  logic [LANE_W-1:0]  lane_sum;
  logic [SUM_W-1:0]   sum_next;

  assign beat_fire = in_valid && in_ready;
  assign beat_last = (beat_cnt == LAST_BEAT);
  // Beat 0 truncates with the incoming mode; the register only takes it on that same edge.
  assign beat_mode = (beat_cnt == '0) ? in_mode : mode_q;
  assign sum_next  = acc + SUM_W'(s1_sum);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    approx_absdiff_lane #(
      .DATA_W  (DATA_W),
      .DROP_LSB(DROP_LSB)
    ) u_lane (
      .a     (in_a[i*DATA_W +: DATA_W]),
      .b     (in_b[i*DATA_W +: DATA_W]),
      .approx(beat_mode == MODE_APPROX),
      .d     (lane_d[i])
    );
  end

  // NOTE: give every always_comb target a default first so no latch is inferred.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum += LANE_W'(lane_d[i]);
  end

`ifdef APPROX_SAD_ERR_MON_EN
  logic [DATA_W-1:0]  lane_x [LANES];
  logic [LANE_W-1:0]  lane_xsum;
  logic [LANE_W-1:0]  s1_xsum;
  logic [SUM_W-1:0]   xacc;
  logic [SUM_W-1:0]   xsum_next;
  logic [SUM_W-1:0]   err_next;

  for (genvar i = 0; i < LANES; i++) begin : g_xlane
    approx_absdiff_lane #(
      .DATA_W  (DATA_W),
      .DROP_LSB(DROP_LSB)
    ) u_xlane (
      .a     (in_a[i*DATA_W +: DATA_W]),
      .b     (in_b[i*DATA_W +: DATA_W]),
      .approx(MODE_EXACT),
      .d     (lane_x[i])
    );
  end

  always_comb begin
    lane_xsum = '0;
    for (int i = 0; i < LANES; i++) lane_xsum += LANE_W'(lane_x[i]);
  end

  assign xsum_next = xacc + SUM_W'(s1_xsum);
  assign err_next  = xsum_next - sum_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_xsum        <= '0;
      xacc           <= '0;
      out_err        <= '0;
      out_err_exceed <= 1'b0;
    end else begin
      if (beat_fire) s1_xsum <= lane_xsum;
      if (state == ACCUM && s1_valid) begin
        if (s1_last) begin
          out_err        <= err_next;
          out_err_exceed <= int'(err_next) > ET_BLOCK;
          xacc           <= '0;
        end else begin
          xacc <= xsum_next;
        end
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      beat_cnt  <= '0;
      mode_q    <= MODE_EXACT;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_mode  <= MODE_EXACT;
    end else begin
      s1_valid <= beat_fire;
      if (beat_fire) begin
        s1_sum   <= lane_sum;
        s1_last  <= beat_last;
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) mode_q <= in_mode;
        if (beat_last) in_ready <= 1'b0;
      end

      case (state)
        ACCUM: begin
          if (s1_valid) begin
            if (s1_last) begin
              out_sum   <= sum_next;
              out_mode  <= mode_q;
              out_valid <= 1'b1;
              acc       <= '0;
              state     <= HOLD;
            end else begin
              acc <= sum_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_sad_accum.sv
// Directed self-checking bench for approx_sad_accum with default parameters.
// Error-monitor ports are connected and checked when APPROX_SAD_ERR_MON_EN is defined.
module tb_approx_sad_accum;

  localparam int DATA_W = 2;
  localparam int LANES  = 4;
  localparam int SUM_W  = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic                    in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [SUM_W-1:0]        out_sum;
  logic                    out_mode;
`ifdef APPROX_SAD_ERR_MON_EN
  logic [SUM_W-1:0]        out_err;
  logic                    out_err_exceed;
`endif

  int n_checks = 0;
  int n_errors = 0;

  approx_sad_accum dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
`ifdef APPROX_SAD_ERR_MON_EN
    .out_err       (out_err),
    .out_err_exceed(out_err_exceed),
`endif
    .out_mode (out_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n beats with every lane carrying the same a/b; optional idle cycle between beats
  // and optional inversion of in_mode on odd beats.
  task automatic send_beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic mode, input int n, input bit gap, input bit toggle);
    for (int i = 0; i < n; i++) begin
      int t;
      in_a     = {LANES{a}};
      in_b     = {LANES{b}};
      in_mode  = (toggle && (i % 2 == 1)) ? ~mode : mode;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 100) begin
        step();
        t++;
      end
      if (t >= 100) check("beat_timeout", 32'd0, 32'd1);
      step();
      if (gap && i < n - 1) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  // Called right after the final beat's handshake edge; counts edges until out_valid.
  task automatic wait_result(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd2);
  endtask

  task automatic check_result(input string tag, input int sum, input logic mode,
                              input int err, input logic exceed);
    check({tag, "_valid"}, out_valid, 32'd1);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_mode"}, out_mode, mode);
`ifdef APPROX_SAD_ERR_MON_EN
    check({tag, "_err"}, out_err, err);
    check({tag, "_exceed"}, out_err_exceed, exceed);
`endif
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, "_drop"}, out_valid, 32'd0);
    check({tag, "_rdy"}, in_ready, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_mode", out_mode, 32'd0);
`ifdef APPROX_SAD_ERR_MON_EN
    check("rst_out_err", out_err, 32'd0);
    check("rst_out_exceed", out_err_exceed, 32'd0);
`endif

    // exact 3-0: 4 lanes * 3 * 8 beats
    send_beats(2'd3, 2'd0, 1'b0, 8, 1'b0, 1'b0);
    check("ex30_busy", in_ready, 32'd0);
    wait_result("ex30");
    check_result("ex30", 96, 1'b0, 0, 1'b0);
    take_result("ex30");

    // approx 3-0: 3 truncates to 2 -> 64, exact 96 -> err 32
    send_beats(2'd3, 2'd0, 1'b1, 8, 1'b0, 1'b0);
    wait_result("ap30");
    check_result("ap30", 64, 1'b1, 32, 1'b1);
    take_result("ap30");

    // approx 1-2: |d|=1 truncates to 0; exact would be 32
    send_beats(2'd1, 2'd2, 1'b1, 8, 1'b0, 1'b0);
    wait_result("ap12");
    check_result("ap12", 0, 1'b1, 32, 1'b1);
    take_result("ap12");

    send_beats(2'd1, 2'd2, 1'b0, 8, 1'b0, 1'b0);
    wait_result("ex12");
    check_result("ex12", 32, 1'b0, 0, 1'b0);
    take_result("ex12");

    // backpressure: hold 5 cycles with a pending beat offered
    out_ready = 1'b0;
    send_beats(2'd2, 2'd1, 1'b0, 8, 1'b0, 1'b0);
    wait_result("bp");
    check_result("bp", 32, 1'b0, 0, 1'b0);
    in_a     = {LANES{2'd2}};
    in_b     = '0;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 32'd0);
      check("bp_hold_valid", out_valid, 32'd1);
      check("bp_hold_sum", out_sum, 32'd32);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_drop", out_valid, 32'd0);
    check("bp_rdy", in_ready, 32'd1);
    send_beats(2'd2, 2'd0, 1'b0, 8, 1'b0, 1'b0);
    wait_result("bp_next");
    check_result("bp_next", 64, 1'b0, 0, 1'b0);
    take_result("bp_next");

    // reset mid-block after 3 beats
    send_beats(2'd3, 2'd0, 1'b1, 3, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_in_ready", in_ready, 32'd1);
    check("rstmid_valid", out_valid, 32'd0);
    check("rstmid_sum", out_sum, 32'd0);
    check("rstmid_mode", out_mode, 32'd0);
    send_beats(2'd0, 2'd1, 1'b0, 8, 1'b0, 1'b0);
    wait_result("rstmid");
    check_result("rstmid", 32, 1'b0, 0, 1'b0);
    take_result("rstmid");

    // reset while a result is pending in HOLD
    out_ready = 1'b0;
    send_beats(2'd3, 2'd0, 1'b1, 8, 1'b0, 1'b0);
    wait_result("rsthold");
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rsthold_valid", out_valid, 32'd0);
    check("rsthold_sum", out_sum, 32'd0);
    check("rsthold_mode", out_mode, 32'd0);
    check("rsthold_rdy", in_ready, 32'd1);

    // gapped beats, in_mode flipped on odd beats: mode latched exact at beat 0
    send_beats(2'd3, 2'd1, 1'b0, 8, 1'b1, 1'b1);
    wait_result("gap");
    check_result("gap", 64, 1'b0, 0, 1'b0);
    take_result("gap");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
